// File: rtl/precision_pkg.sv
// IEEE-754 format helpers shared by the vector max datapath.
package precision_pkg;

    // Total encoded width for a precision name; 0 flags an unknown name.
    function automatic int prec_bits(input string p);
        if (p == "HALF")   return 16;
        if (p == "SINGLE") return 32;
        if (p == "DOUBLE") return 64;
        return 0;
    endfunction

    function automatic int exp_width(input string p);
        if (p == "SINGLE") return 8;
        if (p == "DOUBLE") return 11;
        return 5;
    endfunction

    function automatic int man_width(input string p);
        if (p == "SINGLE") return 23;
        if (p == "DOUBLE") return 52;
        return 10;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= man_w - 1 && i < man_w + exp_w) r[i] = 1'b1;
        end
        return r;
    endfunction

    // NaN: exponent all ones and non-zero mantissa (value right-aligned in x).
    function automatic logic is_nan(input logic [63:0] x, input int exp_w, input int man_w);
        logic exp_ones;
        logic man_nz;
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < man_w && x[i]) man_nz = 1'b1;
            if (i >= man_w && i < man_w + exp_w && !x[i]) exp_ones = 1'b0;
        end
        return exp_ones && man_nz;
    endfunction

endpackage

// File: rtl/vector_max_scalar_float_gt.sv
// Combinational sign-magnitude "strictly greater" compare; NaN handling is left to the caller.
module float_gt
    import precision_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            a_gt_b,
    output logic            a_is_nan
);

    logic            sign_a;
    logic            sign_b;
    logic [BITS-2:0] mag_a;
    logic [BITS-2:0] mag_b;

    assign sign_a = a[BITS-1];
    assign sign_b = b[BITS-1];
    assign mag_a  = a[BITS-2:0];
    assign mag_b  = b[BITS-2:0];

    assign a_is_nan = is_nan(64'(a), EXP_W, MAN_W);

    // +0 and -0 are equal; otherwise positives order by magnitude, negatives inversely.
    always_comb begin
        a_gt_b = 1'b0;
        if (mag_a == '0 && mag_b == '0) begin
            a_gt_b = 1'b0;
        end else if (sign_a != sign_b) begin
            a_gt_b = sign_b;
        end else if (!sign_a) begin
            a_gt_b = (mag_a > mag_b);
        end else begin
            a_gt_b = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/vector_max_scalar.sv
// Iterative vector max: one element compared per clock, result presented with the vector.
//
// state | meaning
// IDLE  | in_ready high, waiting for a vector
// SCAN  | comparing vec[ptr] against the running max, one element per clock
// DONE  | out_valid pulse, results stable for this one cycle
module vector_max_scalar
    import precision_pkg::*;
#(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    N         = 3,
    localparam int   IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  a [N],
    output logic             out_valid,
    output logic [BITS-1:0]  a_out [N],
    output logic [BITS-1:0]  max_out,
    output logic [IDX_W-1:0] max_idx
);

    localparam int EXP_W = exp_width(PRECISION);
    localparam int MAN_W = man_width(PRECISION);
    localparam logic [BITS-1:0] QNAN = BITS'(canon_qnan(EXP_W, MAN_W));

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (BITS != prec_bits(PRECISION) || N < 1) begin : g_bad_cfg
            $fatal(1, "vector_max_scalar: BITS must match PRECISION and N must be >= 1");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [BITS-1:0]  vec_q [N];
    logic [BITS-1:0]  vec_d [N];
    logic [BITS-1:0]  max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             nan_seen_q, nan_seen_d;
    logic [BITS-1:0]  res_max_q, res_max_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;

    logic [BITS-1:0]  cand;
    logic             cand_gt;
    logic             cand_nan;

    float_gt #(.BITS(BITS), .EXP_W(EXP_W), .MAN_W(MAN_W)) u_gt (
        .a        (cand),
        .b        (max_q),
        .a_gt_b   (cand_gt),
        .a_is_nan (cand_nan)
    );

    // Candidate mux; compare against each index so ptr width never has to match the array range.
    always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q == IDX_W'(i)) cand = vec_q[i];
        end
    end

    // Next-state: accept, scan with sticky NaN, latch results on the way into DONE.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        max_d      = max_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        nan_seen_d = nan_seen_q;
        res_max_d  = res_max_q;
        res_idx_d  = res_idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d      = a;
                    nan_seen_d = is_nan(64'(a[0]), EXP_W, MAN_W);
                    max_d      = nan_seen_d ? QNAN : a[0];
                    idx_d      = '0;
                    ptr_d      = IDX_W'(1);
                    if (N > 1) begin
                        state_d = SCAN;
                    end else begin
                        state_d   = DONE;
                        res_max_d = max_d;
                        res_idx_d = '0;
                    end
                end
            end
            SCAN: begin
                if (!nan_seen_q) begin
                    if (cand_nan) begin
                        nan_seen_d = 1'b1;
                        max_d      = QNAN;
                        idx_d      = ptr_q;
                    end else if (cand_gt) begin
                        max_d = cand;
                        idx_d = ptr_q;
                    end
                end
                if (ptr_q == IDX_W'(N - 1)) begin
                    state_d   = DONE;
                    res_max_d = max_d;
                    res_idx_d = idx_d;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any vector in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            vec_q      <= '{default: '0};
            max_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            nan_seen_q <= 1'b0;
            res_max_q  <= '0;
            res_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            max_q      <= max_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            nan_seen_q <= nan_seen_d;
            res_max_q  <= res_max_d;
            res_idx_q  <= res_idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign a_out     = vec_q;
    assign max_out   = res_max_q;
    assign max_idx   = res_idx_q;

endmodule

// File: tb/tb_vector_max_scalar.sv
// Self-checking bench for vector_max_scalar (HALF, N=3 main instance, N=1 side instance).
module tb_vector_max_scalar;

    typedef struct packed {
        logic [2:0][15:0] v;
        logic [15:0]      mx;
        logic [1:0]       idx;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in [3];
    logic        out_valid;
    logic [15:0] a_out [3];
    logic [15:0] max_out;
    logic [1:0]  max_idx;

    logic        in_valid1;
    logic        in_ready1;
    logic [15:0] a1 [1];
    logic        out_valid1;
    logic [15:0] a_out1 [1];
    logic [15:0] max_out1;
    logic [0:0]  max_idx1;

    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];

    vector_max_scalar #(.BITS(16), .PRECISION("HALF"), .N(3)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a_in),
        .out_valid(out_valid), .a_out(a_out), .max_out(max_out), .max_idx(max_idx)
    );

    vector_max_scalar #(.BITS(16), .PRECISION("HALF"), .N(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1),
        .out_valid(out_valid1), .a_out(a_out1), .max_out(max_out1), .max_idx(max_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0][15:0] mkv(input logic [15:0] e0, input logic [15:0] e1,
                                             input logic [15:0] e2);
        return {e2, e1, e0};
    endfunction

    function automatic logic h_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    endfunction

    // Ordering key: signed integer where -0 and +0 both map to 0.
    function automatic int h_key(input logic [15:0] x);
        int m;
        m = int'(x[14:0]);
        return x[15] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [2:0][15:0] v);
        exp_t e;
        int   best;
        e.v   = v;
        e.mx  = v[0];
        e.idx = 2'd0;
        best  = h_key(v[0]);
        if (h_nan(v[0])) begin
            e.mx = 16'h7E00;
            return e;
        end
        for (int i = 1; i < 3; i++) begin
            if (h_nan(v[i])) begin
                e.mx  = 16'h7E00;
                e.idx = 2'(i);
                return e;
            end
            if (h_key(v[i]) > best) begin
                best  = h_key(v[i]);
                e.mx  = v[i];
                e.idx = 2'(i);
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        a1[0]     = '0;
        for (int i = 0; i < 3; i++) a_in[i] = '0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (max_out !== 16'h0) begin errors++; $display("FAIL reset_max_out: got %h want 0000", max_out); end
        checks++; if (max_idx !== 2'd0) begin errors++; $display("FAIL reset_max_idx: got %0d want 0", max_idx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_out[i] !== 16'h0) begin errors++; $display("FAIL reset_a_out[%0d]: got %h want 0000", i, a_out[i]); end
        end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid_n1: got %b want 0", out_valid1); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max_values();
        logic [2:0][15:0] tbl [8];
        exp_t got;
        int   w;
        int   cyc;
        tbl[0] = mkv(16'h3C00, 16'h4000, 16'hBC00);
        tbl[1] = mkv(16'hC000, 16'hBC00, 16'hC200);
        tbl[2] = mkv(16'h8000, 16'h0000, 16'h8000);
        tbl[3] = mkv(16'hFC00, 16'hFC00, 16'h7C00);
        tbl[4] = mkv(16'h3C00, 16'h7E01, 16'h4000);
        tbl[5] = mkv(16'h0001, 16'h0003, 16'h0002);
        tbl[6] = mkv(16'hFE00, 16'h7C00, 16'h7C01);
        tbl[7] = mkv(16'h0000, 16'h8000, 16'h8001);
        for (int t = 0; t < 8; t++) begin
            w = 0;
            while (!in_ready && w < 20) begin @(negedge clk); w++; end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_ready_timeout: got %b want 1", t, in_ready); end
            sb.push_back(model(tbl[t]));
            for (int i = 0; i < 3; i++) a_in[i] = tbl[t][i];
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 20);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_out_timeout: got %b want 1", t, out_valid); end
            checks++; if (cyc != 3) begin errors++; $display("FAIL vec%0d_latency: got %0d want 3", t, cyc); end
            got = sb.pop_front();
            checks++; if (max_out !== got.mx) begin errors++; $display("FAIL vec%0d_max_out: got %h want %h", t, max_out, got.mx); end
            checks++; if (max_idx !== got.idx) begin errors++; $display("FAIL vec%0d_max_idx: got %0d want %0d", t, max_idx, got.idx); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (a_out[i] !== got.v[i]) begin errors++; $display("FAIL vec%0d_a_out[%0d]: got %h want %h", t, i, a_out[i], got.v[i]); end
            end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_pulse_width: got %b want 0", t, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0][15:0] v;
        exp_t got;
        for (int k = 0; k < 12; k++) begin
            checks++; if (in_ready !== (k % 4 == 0)) begin errors++; $display("FAIL b2b_in_ready k=%0d: got %b want %b", k, in_ready, (k % 4 == 0)); end
            checks++; if (out_valid !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_out_valid k=%0d: got %b want %b", k, out_valid, (k % 4 == 3)); end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_output k=%0d: got out_valid with empty scoreboard", k);
                end else begin
                    got = sb.pop_front();
                    if (max_out !== got.mx || max_idx !== got.idx || a_out[0] !== got.v[0] ||
                        a_out[1] !== got.v[1] || a_out[2] !== got.v[2]) begin
                        errors++;
                        $display("FAIL b2b_result k=%0d: got max=%h idx=%0d a=%h,%h,%h want max=%h idx=%0d a=%h,%h,%h",
                                 k, max_out, max_idx, a_out[0], a_out[1], a_out[2],
                                 got.mx, got.idx, got.v[0], got.v[1], got.v[2]);
                    end
                end
            end
            if (k < 10) begin
                v = mkv(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                        16'($urandom_range(0, 65535)));
                for (int i = 0; i < 3; i++) a_in[i] = v[i];
                in_valid = 1'b1;
                if (k % 4 == 0) sb.push_back(model(v));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_single();
        logic [15:0] vals [3];
        logic [15:0] want;
        vals[0] = 16'h4500;
        vals[1] = 16'h7C01;
        vals[2] = 16'hFC00;
        for (int t = 0; t < 3; t++) begin
            want = h_nan(vals[t]) ? 16'h7E00 : vals[t];
            a1[0]     = vals[t];
            in_valid1 = 1'b1;
            @(posedge clk);
            #1 in_valid1 = 1'b0;
            @(negedge clk);
            checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL n1_%0d_out_valid: got %b want 1", t, out_valid1); end
            checks++; if (max_out1 !== want) begin errors++; $display("FAIL n1_%0d_max_out: got %h want %h", t, max_out1, want); end
            checks++; if (max_idx1 !== 1'b0) begin errors++; $display("FAIL n1_%0d_max_idx: got %0d want 0", t, max_idx1); end
            checks++; if (a_out1[0] !== vals[t]) begin errors++; $display("FAIL n1_%0d_a_out: got %h want %h", t, a_out1[0], vals[t]); end
            @(negedge clk);
            checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL n1_%0d_return_idle: got valid=%b ready=%b want 0/1", t, out_valid1, in_ready1); end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [2:0][15:0] v;
        exp_t got;
        int   pulses;
        int   cyc;
        v = mkv(16'h3C00, 16'h4000, 16'hBC00);
        sb.push_back(model(v));
        for (int i = 0; i < 3; i++) a_in[i] = v[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        checks++; if (max_out !== 16'h0 || max_idx !== 2'd0) begin errors++; $display("FAIL rst_mid_max: got %h/%0d want 0000/0", max_out, max_idx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_out[i] !== 16'h0) begin errors++; $display("FAIL rst_mid_a_out[%0d]: got %h want 0000", i, a_out[i]); end
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_stray_pulse: got %0d pulses want 0", pulses); end
        v = mkv(16'h4000, 16'h4400, 16'h3C00);
        sb.push_back(model(v));
        for (int i = 0; i < 3; i++) a_in[i] = v[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 20);
        checks++; if (out_valid !== 1'b1 || cyc != 3) begin errors++; $display("FAIL rst_after_latency: got valid=%b cyc=%0d want 1/3", out_valid, cyc); end
        got = sb.pop_front();
        checks++; if (max_out !== got.mx || max_idx !== got.idx) begin errors++; $display("FAIL rst_after_result: got %h/%0d want %h/%0d", max_out, max_idx, got.mx, got.idx); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_max_values();
        test_back_to_back();
        test_single();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
